// File: rtl/vme_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// vme_seq_pkg
// Shared definitions for the VME command sequencer and its command FIFO.
//   VME_RD_BIT / VME_WR_BIT : command-word bits flagging a read or a write
//   VME_IDLE_MASK           : default pattern OR-ed into every command word
//   MAX_DATA_W              : widest data path a FIFO entry can carry
//   seq_state_t             : sequencer FSM states
//   cmd_entry_t             : one queued command {rd, cmd, data}
//   ENTRY_W                 : width of a flattened cmd_entry_t
// ---------------------------------------------------------------------------
package vme_seq_pkg;

  localparam int          VME_RD_BIT    = 25;
  localparam int          VME_WR_BIT    = 24;
  localparam logic [31:0] VME_IDLE_MASK = 32'h00A80000;

  // Entries are sized for the widest legal data path so the package does not
  // depend on the sequencer's DATA_W; narrower data is zero-extended on entry.
  localparam int MAX_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESULT
  } seq_state_t;

  typedef struct packed {
    logic                  rd;
    logic [15:0]           cmd;
    logic [MAX_DATA_W-1:0] data;
  } cmd_entry_t;

  localparam int ENTRY_W = $bits(cmd_entry_t);

endpackage

// File: rtl/vme_cmd_sequencer_fifo.sv
// ---------------------------------------------------------------------------
// vme_cmd_fifo
// Synchronous command FIFO with sticky overflow and synchronous flush.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_push, i_din  : enqueue one entry (dropped while full)
//   i_pop          : dequeue the head entry (ignored while empty)
//   i_flush        : empty the FIFO next cycle; beats a simultaneous push
//   o_dout         : current head entry, valid whenever o_count != 0
//   o_full         : occupancy equals DEPTH
//   o_count        : occupancy, 0..DEPTH
//   o_overflow     : sticky, set by any push attempted while full
// ---------------------------------------------------------------------------
module vme_cmd_fifo
  import vme_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = ENTRY_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic [AW:0]   o_count,
  output logic          o_overflow
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_doPush;
  logic          w_doPop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same
  // cycle, which keeps the full/overflow decision independent of the reader.
  assign o_full   = (r_count == FullCount);
  assign w_doPush = i_push && !o_full && !i_flush;
  assign w_doPop  = i_pop && (r_count != '0);

  // Pointer, occupancy and overflow bookkeeping. Pointers are AW bits wide so
  // they wrap modulo DEPTH on their own. Flush drops everything by snapping the
  // read pointer onto the write pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_push && o_full) begin
        r_overflow <= 1'b1;
      end
      if (i_flush) begin
        r_rdPtr <= r_wrPtr;
        r_count <= '0;
      end else begin
        if (w_doPush) begin
          r_wrPtr <= r_wrPtr + 1'b1;
        end
        if (w_doPop) begin
          r_rdPtr <= r_rdPtr + 1'b1;
        end
        r_count <= r_count + (AW+1)'(w_doPush) - (AW+1)'(w_doPop);
      end
    end
  end

  // Storage array. It carries no reset since the pointers and count define
  // which slots hold meaningful data.
  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

  assign o_dout     = r_mem[r_rdPtr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/vme_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// vme_cmd_sequencer
// Queues VME read/write commands and issues them one at a time to the VME
// decode logic, returning one result per command.
//   i_clk, i_rst                       : clock, async active-high reset
//   i_push, i_push_rd, i_push_cmd,
//   i_push_data                        : enqueue a command (data unused for reads)
//   i_flush                            : discard queued (not in-flight) commands
//   o_full, o_count, o_overflow        : FIFO status
//   i_vme_cmd_rd                       : VME side can accept a command
//   i_vme_dat_wr, i_vme_dat_reg_out    : VME side result strobe and data
//   o_start, o_vme_cmd_reg,
//   o_vme_dat_reg_in                   : command strobe, command word, data word
//   o_res_valid, o_res_rd, o_res_cmd,
//   o_res_data, o_res_timeout          : result held until i_res_ack
//   i_res_ack                          : consume the current result
//   o_busy                             : command in flight or queue not empty
// ---------------------------------------------------------------------------
module vme_cmd_sequencer
  import vme_seq_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter int          AW      = 4,
  parameter int          DATA_W  = 16,
  parameter logic [31:0] MASK    = VME_IDLE_MASK,
  parameter int          TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_push_rd,
  input  logic [15:0]       i_push_cmd,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_flush,
  output logic              o_full,
  output logic [AW:0]       o_count,
  output logic              o_overflow,
  input  logic              i_vme_cmd_rd,
  input  logic              i_vme_dat_wr,
  input  logic [31:0]       i_vme_dat_reg_out,
  output logic              o_start,
  output logic [31:0]       o_vme_cmd_reg,
  output logic [31:0]       o_vme_dat_reg_in,
  output logic              o_res_valid,
  output logic              o_res_rd,
  output logic [15:0]       o_res_cmd,
  output logic [DATA_W-1:0] o_res_data,
  output logic              o_res_timeout,
  input  logic              i_res_ack,
  output logic              o_busy
);

  // The WAIT state lasts at most TIMEOUT cycles; the counter starts at 0 in
  // the first WAIT cycle, so the last permitted cycle sees TIMEOUT-1.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  seq_state_t        r_state;
  seq_state_t        w_nextState;
  logic              r_rd;
  logic [15:0]       r_cmd;
  logic [DATA_W-1:0] r_data;
  logic [7:0]        r_toCnt;
  logic              r_resRd;
  logic [15:0]       r_resCmd;
  logic [DATA_W-1:0] r_resData;
  logic              r_resTimeout;

  logic [ENTRY_W-1:0] w_pushEntry;
  logic [ENTRY_W-1:0] w_headBits;
  cmd_entry_t         w_head;
  logic               w_pop;
  logic               w_latch;
  logic               w_isTimeout;
  logic               w_unused;

  assign w_pushEntry = {i_push_rd, i_push_cmd, MAX_DATA_W'(i_push_data)};
  assign w_head      = cmd_entry_t'(w_headBits);

  // Bits above DATA_W in the FIFO entry and in the VME result bus are never
  // looked at; folding them here keeps them visibly intentional.
  assign w_unused = ^{w_head.data, i_vme_dat_reg_out};

  vme_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (i_push),
    .i_din      (w_pushEntry),
    .i_pop      (w_pop),
    .i_flush    (i_flush),
    .o_dout     (w_headBits),
    .o_full     (o_full),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  // Next-state and output decode. The command word is only meaningful in the
  // single ISSUE cycle; everywhere else the VME bus sees the idle mask. A
  // result strobe in the final WAIT cycle takes priority over the timeout.
  always_comb begin
    w_nextState      = r_state;
    w_pop            = 1'b0;
    w_latch          = 1'b0;
    w_isTimeout      = 1'b0;
    o_start          = 1'b0;
    o_vme_cmd_reg    = MASK;
    o_vme_dat_reg_in = '0;
    o_res_valid      = 1'b0;
    case (r_state)
      IDLE: begin
        if ((o_count != '0) && i_vme_cmd_rd) begin
          w_pop       = 1'b1;
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        o_start       = 1'b1;
        o_vme_cmd_reg = {16'b0, r_cmd} | MASK;
        if (r_rd) begin
          o_vme_cmd_reg[VME_RD_BIT] = 1'b1;
        end else begin
          o_vme_cmd_reg[VME_WR_BIT] = 1'b1;
          o_vme_dat_reg_in          = 32'(r_data);
        end
        w_nextState = WAIT;
      end
      WAIT: begin
        if (i_vme_dat_wr) begin
          w_latch     = 1'b1;
          w_nextState = RESULT;
        end else if (r_toCnt == TimeoutLast) begin
          w_latch     = 1'b1;
          w_isTimeout = 1'b1;
          w_nextState = RESULT;
        end
      end
      RESULT: begin
        o_res_valid = 1'b1;
        if (i_res_ack) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register, in-flight command capture, timeout counter and result
  // capture. Reset drops any in-flight command without producing a result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_rd         <= 1'b0;
      r_cmd        <= '0;
      r_data       <= '0;
      r_toCnt      <= '0;
      r_resRd      <= 1'b0;
      r_resCmd     <= '0;
      r_resData    <= '0;
      r_resTimeout <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_pop) begin
        r_rd   <= w_head.rd;
        r_cmd  <= w_head.cmd;
        r_data <= w_head.data[DATA_W-1:0];
      end
      if (r_state == ISSUE) begin
        r_toCnt <= '0;
      end else if (r_state == WAIT) begin
        r_toCnt <= r_toCnt + 8'd1;
      end
      if (w_latch) begin
        r_resRd      <= r_rd;
        r_resCmd     <= r_cmd;
        r_resTimeout <= w_isTimeout;
        if (w_isTimeout) begin
          r_resData <= '0;
        end else if (r_rd) begin
          r_resData <= i_vme_dat_reg_out[DATA_W-1:0];
        end else begin
          r_resData <= r_data;
        end
      end
    end
  end

  assign o_res_rd      = r_resRd;
  assign o_res_cmd     = r_resCmd;
  assign o_res_data    = r_resData;
  assign o_res_timeout = r_resTimeout;
  assign o_busy        = (r_state != IDLE) || (o_count != '0);

endmodule

// File: doc/vme_cmd_sequencer.md
Name: vme_cmd_sequencer

Overview:
Synthesizable, parametrised VME command sequencer for ODMB in-system test and bring-up.
- Queues R/W VME commands in a FIFO.
- Issues them one at a time to the VME command interface using the start / vme_cmd_rd / vme_dat_wr handshake.
- Returns one result per command, carrying read-back data, echoed write data, or a timeout flag.
- Sits between a host-side command source (PC/DCFEB loopback or test controller) and the VME decode logic.

Parameters:
DEPTH, 16, command FIFO entries (power of 2, ≥2)
AW, 4, log2(DEPTH)
DATA_W, 16, data width of commands and results (≤32)
MASK, 32'h00A80000, OR-ed into every issued command word and driven on vme_cmd_reg when idle
TIMEOUT, 255, max cycles waiting for vme_dat_wr (8-bit counter, 1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
push  in  1  enqueue command
push_rd  in  1  1=read command, 0=write command
push_cmd  in  16  VME instruction (address/command field)
push_data  in  DATA_W  write data; ignored for reads
flush  in  1  synchronous clear of FIFO contents (not the in-flight command)
full  out  1  FIFO full
count  out  AW+1  FIFO occupancy
overflow  out  1  sticky: push while full
vme_cmd_rd  in  1  VME side ready for a command
vme_dat_wr  in  1  VME side result strobe
vme_dat_reg_out  in  32  VME side result data
start  out  1  one-cycle command strobe
vme_cmd_reg  out  32  issued command word
vme_dat_reg_in  out  32  issued data word
res_valid  out  1  result available
res_rd  out  1  result was for a read
res_cmd  out  16  instruction of the result
res_data  out  DATA_W  read data (read), written data (write), 0 (timeout)
res_timeout  out  1  result terminated by timeout
res_ack  in  1  consume result
busy  out  1  state≠IDLE or count≠0

Behaviour:
Reset values:
- All outputs 0, except vme_cmd_reg = MASK.
- FIFO empty, state IDLE, overflow cleared.
- Reset mid-operation abandons the in-flight command; no result is produced for it.

FIFO:
- Registered, first-word fall-through not required.
- push while full: ignored and sets overflow. This holds even if a pop happens in the same cycle.
- push while not full: accepted, including in the same cycle as a pop.
- flush: sets count to 0 next cycle. flush wins over a simultaneous push.
- Pointers wrap modulo DEPTH.

FSM states IDLE, ISSUE, WAIT, RESULT:
- IDLE: if count>0 and vme_cmd_rd=1 → pop the head, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - start=1.
  - vme_cmd_reg = {16'b0,cmd} | MASK, with bit25=1 for a read or bit24=1 for a write.
  - vme_dat_reg_in = zero-extended data (0 for reads).
  - Timeout counter loads 0. Go to WAIT.
- WAIT:
  - start=0; vme_cmd_reg=MASK; vme_dat_reg_in=0.
  - vme_dat_wr=1 → latch result, res_timeout=0, go to RESULT.
    - Read: res_data = vme_dat_reg_out[DATA_W-1:0].
    - Write: res_data = issued data.
  - Otherwise the counter increments. When the counter = TIMEOUT with no strobe → res_timeout=1, res_data=0, go to RESULT.
  - If vme_dat_wr and the timeout coincide, vme_dat_wr wins.
- RESULT:
  - res_valid=1; res_* held stable.
  - res_ack=1 → res_valid=0 next cycle, go to IDLE.
  - No new issue until acked (back-pressure).

Other rules:
- vme_dat_wr outside WAIT is ignored.
- Latency: push into an empty FIFO with vme_cmd_rd high → start asserts 2 cycles later (1 cycle for occupancy, 1 for IDLE→ISSUE).
- Best case 1 command per 4 cycles.

Decomposition:
Shared package vme_seq_pkg holds:
- constants VME_RD_BIT=25, VME_WR_BIT=24, VME_IDLE_MASK=32'h00A80000;
- state enum {IDLE, ISSUE, WAIT, RESULT};
- packed struct cmd_entry_t {rd, cmd[15:0], data[DATA_W-1:0]}.

One sub-module, vme_cmd_fifo: parametrised synchronous FIFO with push/pop/flush/full/count/overflow. The FSM and result registers live in the top.

Test Plan:
1. Push W cmd 0x1020 data 0x00AB, vme_cmd_rd=1 → start for 1 cycle 2 cycles later with vme_cmd_reg=0x01A81020, vme_dat_reg_in=0x000000AB. Then vme_dat_wr → res_data=0x00AB, res_rd=0.
2. Push R cmd 0x4100, then answer with vme_dat_wr and vme_dat_reg_out=0xDEAD5A5A → vme_cmd_reg=0x02A84100 at start, res_data=0x5A5A, res_rd=1, res_timeout=0.
3. R cmd with no vme_dat_wr, TIMEOUT=255 → res_valid rises 256 cycles after start with res_timeout=1, res_data=0. Then a late vme_dat_wr is ignored.
4. Push 17 commands with vme_cmd_rd=0 → full=1 at count=16, overflow=1. Then raise vme_cmd_rd and ack each result → 16 results in push order, instructions intact.
5. Hold res_ack=0 for 50 cycles with 3 queued commands → exactly one start until ack. After ack, the next start follows IDLE→ISSUE.
6. Assert rst during WAIT, and separately flush with count=5 → no result produced, count=0, vme_cmd_reg=0x00A80000, busy=0.
